phy_rx_detect: RTL and testbench

//  PHY-side Receiver Detection Sequencer: the responder to the LTSSM Detect.Active request.
//  On request, drives the PIPE TxDetectRx pulse on each enabled lane, samples the per-lane

---
 rtl/phy_rx_detect_if.sv | 33 +++
 rtl/phy_rx_detect.sv | 136 +++++++++++++
 tb/tb_phy_rx_detect.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/phy_rx_detect_if.sv
// Bundle between the LTSSM Detect controller / analog front end (master) and
// the PHY receiver detection sequencer (slave).
//
// Handshake: detect_req_i is a level request. The sequencer starts only on a
// request seen in IDLE, answers with a one-cycle detect_done_o pulse when
// lane_detect_o/any_detect_o are valid, and does not start again until the
// request has been dropped and raised once more. Dropping the request before
// completion aborts the sequence without a done pulse.
interface phy_rx_detect_if #(
    parameter int NUM_LANES = 4
);
    logic                 detect_req_i;
    logic [NUM_LANES-1:0] lanes_en_i;
    logic [NUM_LANES-1:0] rx_sense_i;
    logic                 tx_elec_idle_o;
    logic                 tx_detect_rx_o;
    logic                 busy_o;
    logic                 detect_done_o;
    logic [NUM_LANES-1:0] lane_detect_o;
    logic                 any_detect_o;

    modport master (
        output detect_req_i, lanes_en_i, rx_sense_i,
        input  tx_elec_idle_o, tx_detect_rx_o, busy_o,
               detect_done_o, lane_detect_o, any_detect_o
    );

    modport slave (
        input  detect_req_i, lanes_en_i, rx_sense_i,
        output tx_elec_idle_o, tx_detect_rx_o, busy_o,
               detect_done_o, lane_detect_o, any_detect_o
    );
endinterface

// File: rtl/phy_rx_detect.sv
// PHY-side receiver detection sequencer. Two settle+pulse passes per request;
// a lane is reported present only when both passes sensed a receiver load.
module phy_rx_detect #(
    parameter int NUM_LANES     = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int PULSE_CYCLES  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    phy_rx_detect_if.slave    bus,
    output logic [1:0]        state_o
);
    localparam int MAX_CYCLES = (SETTLE_CYCLES > PULSE_CYCLES) ? SETTLE_CYCLES : PULSE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        PULSE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pass_q, pass_d;
    logic [NUM_LANES-1:0] pass0_q, pass0_d;
    logic [NUM_LANES-1:0] lane_q, lane_d;
    logic                 any_q, any_d;
    logic                 done_q, done_d;
    logic [NUM_LANES-1:0] sense_meta_q, rx_sense_s;
    logic [NUM_LANES-1:0] smp;

    // Two-flop synchroniser for the asynchronous analog comparator outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sense_meta_q <= '0;
            rx_sense_s   <= '0;
        end else begin
            sense_meta_q <= bus.rx_sense_i;
            rx_sense_s   <= sense_meta_q;
        end
    end

    // Lanes disabled at capture time never count as detected.
    assign smp = rx_sense_s & bus.lanes_en_i;

    // State, counter and result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            pass0_q <= '0;
            lane_q  <= '0;
            any_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            pass0_q <= pass0_d;
            lane_q  <= lane_d;
            any_q   <= any_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: settle/pulse twice, combine both passes, wait for req low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        pass0_d = pass0_q;
        lane_d  = lane_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.detect_req_i) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LOAD;
                    pass_d  = 1'b0;
                    pass0_d = '0;
                    lane_d  = '0;
                end
            end
            SETTLE: begin
                if (!bus.detect_req_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            PULSE: begin
                if (!bus.detect_req_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    if (!pass_q) begin
                        pass0_d = smp;
                        pass_d  = 1'b1;
                        state_d = SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end else begin
                        lane_d  = pass0_q & smp;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                if (!bus.detect_req_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        any_d = |lane_d;
    end

    assign bus.tx_elec_idle_o = 1'b1;
    assign bus.tx_detect_rx_o = (state_q == PULSE);
    assign bus.busy_o         = (state_q == SETTLE) || (state_q == PULSE);
    assign bus.detect_done_o  = done_q;
    assign bus.lane_detect_o  = lane_q;
    assign bus.any_detect_o   = any_q;
    assign state_o            = state_q;
endmodule

// File: tb/tb_phy_rx_detect.sv
// Directed bench for phy_rx_detect with default parameters.
module tb_phy_rx_detect;
    localparam int NL = 4;

    logic       clk;
    logic       rst;
    logic [1:0] state;
    int         n_checks = 0;
    int         n_pass   = 0;

    phy_rx_detect_if #(.NUM_LANES(NL)) bus ();

    phy_rx_detect #(.NUM_LANES(NL), .SETTLE_CYCLES(16), .PULSE_CYCLES(8)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bus     (bus.slave),
        .state_o (state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Drops the request, then raises it and runs until detect_done_o (bounded).
    // s2 is applied to rx_sense once the first pulse has ended.
    task automatic run_seq(input logic [3:0] en, input logic [3:0] s1, input logic [3:0] s2,
                           output int lat, output int hi, output int gap, output int dw);
        int  n;
        bit  prev_tx, fell, done;
        bus.detect_req_i = 1'b0;
        bus.lanes_en_i   = en;
        bus.rx_sense_i   = s1;
        repeat (3) @(negedge clk);
        bus.detect_req_i = 1'b1;
        n = 0; hi = 0; gap = 0; dw = 0;
        prev_tx = 1'b0; fell = 1'b0; done = 1'b0;
        while (!done && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.tx_detect_rx_o) hi++;
            if (!bus.tx_detect_rx_o && prev_tx && !fell) begin
                fell = 1'b1;
                bus.rx_sense_i = s2;
            end
            if (fell && !bus.tx_detect_rx_o && hi == 8) gap++;
            prev_tx = bus.tx_detect_rx_o;
            if (bus.detect_done_o) done = 1'b1;
        end
        lat = done ? n : -1;
        // Done pulse width: count further high samples over a few cycles.
        dw = done ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.detect_done_o) dw++;
        end
    endtask

    initial begin
        int lat, hi, gap, dw, done_seen;
        bus.detect_req_i = 1'b0;
        bus.lanes_en_i   = '0;
        bus.rx_sense_i   = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_state",     32'(state), 32'd0);
        check("rst_elec_idle", 32'(bus.tx_elec_idle_o), 32'd1);
        check("rst_txdet",     32'(bus.tx_detect_rx_o), 32'd0);
        check("rst_busy",      32'(bus.busy_o), 32'd0);
        check("rst_done",      32'(bus.detect_done_o), 32'd0);
        check("rst_lanes",     32'(bus.lane_detect_o), 32'd0);
        check("rst_any",       32'(bus.any_detect_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // T2 full detect
        run_seq(4'hF, 4'hF, 4'hF, lat, hi, gap, dw);
        check("t2_latency", 32'(lat), 32'd49);
        check("t2_pulse_hi", 32'(hi), 32'd16);
        check("t2_gap",      32'(gap), 32'd16);
        check("t2_done_w",   32'(dw), 32'd1);
        check("t2_lanes",    32'(bus.lane_detect_o), 32'hF);
        check("t2_any",      32'(bus.any_detect_o), 32'd1);
        check("t2_idle",     32'(bus.tx_elec_idle_o), 32'd1);
        check("t2_state",    32'(state), 32'd3);

        // T3 masking
        run_seq(4'b0101, 4'hF, 4'hF, lat, hi, gap, dw);
        check("t3_latency", 32'(lat), 32'd49);
        check("t3_lanes",   32'(bus.lane_detect_o), 32'h5);
        check("t3_any",     32'(bus.any_detect_o), 32'd1);

        // T6a abort at cycle 20 (mid first pulse)
        bus.detect_req_i = 1'b0;
        bus.lanes_en_i   = 4'hF;
        bus.rx_sense_i   = 4'hF;
        repeat (3) @(negedge clk);
        bus.detect_req_i = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t6_in_pulse", 32'(bus.tx_detect_rx_o), 32'd1);
        bus.detect_req_i = 1'b0;
        @(negedge clk);
        check("t6_abort_state", 32'(state), 32'd0);
        check("t6_abort_txdet", 32'(bus.tx_detect_rx_o), 32'd0);
        check("t6_abort_busy",  32'(bus.busy_o), 32'd0);
        done_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.detect_done_o) done_seen++;
        end
        check("t6_abort_nodone", 32'(done_seen), 32'd0);
        check("t6_abort_lanes",  32'(bus.lane_detect_o), 32'd0);

        // T4 disagreement between passes
        run_seq(4'hF, 4'h3, 4'h1, lat, hi, gap, dw);
        check("t4_latency", 32'(lat), 32'd49);
        check("t4_lanes",   32'(bus.lane_detect_o), 32'h1);
        check("t4_any",     32'(bus.any_detect_o), 32'd1);

        // T5 no receiver
        run_seq(4'hF, 4'h0, 4'h0, lat, hi, gap, dw);
        check("t5_latency", 32'(lat), 32'd49);
        check("t5_done_w",  32'(dw), 32'd1);
        check("t5_lanes",   32'(bus.lane_detect_o), 32'h0);
        check("t5_any",     32'(bus.any_detect_o), 32'd0);

        // T6b hold request after DONE: no restart
        run_seq(4'hF, 4'hA, 4'hA, lat, hi, gap, dw);
        check("t6_hold_lanes", 32'(bus.lane_detect_o), 32'hA);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.detect_done_o || bus.busy_o) done_seen++;
        end
        check("t6_hold_norestart", 32'(done_seen), 32'd0);
        check("t6_hold_state",     32'(state), 32'd3);
        bus.detect_req_i = 1'b0;
        @(negedge clk);
        check("t6_rearm_idle",  32'(state), 32'd0);
        check("t6_rearm_held",  32'(bus.lane_detect_o), 32'hA);
        bus.detect_req_i = 1'b1;
        @(negedge clk);
        check("t6_rearm_busy",  32'(bus.busy_o), 32'd1);
        check("t6_rearm_clear", 32'(bus.lane_detect_o), 32'h0);
        check("t6_rearm_any",   32'(bus.any_detect_o), 32'd0);

        // T1 reset mid-PULSE (reuse the running sequence: now at cycle 1)
        repeat (18) @(posedge clk);
        @(negedge clk);
        check("t1_in_pulse", 32'(bus.tx_detect_rx_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t1_txdet", 32'(bus.tx_detect_rx_o), 32'd0);
        check("t1_lanes", 32'(bus.lane_detect_o), 32'h0);
        check("t1_idle",  32'(bus.tx_elec_idle_o), 32'd1);
        check("t1_state", 32'(state), 32'd0);
        check("t1_busy",  32'(bus.busy_o), 32'd0);
        bus.detect_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
